// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_pkg
// Description : Shared types for the multi-cycle ALU.
//               - The ALU op enum and the compare op enum.
//               - The FSM state enum.
//               - The list of legal XLEN values.
//               - A helper that says which ops use the iterative unit.
//               Macro ALU_MC_DIV_EN, when defined, makes DIVU/REMU
//               iterative ops. Otherwise they are undefined ops.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SAME = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIVU = 4'd10,
        OP_REMU = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_OTHER    = 3'd0,
        CMP_EQUAL    = 3'd1,
        CMP_UNEQUAL  = 3'd2,
        CMP_LESS     = 3'd3,
        CMP_GREATER  = 3'd4,
        CMP_LESSU    = 3'd5,
        CMP_GREATERU = 3'd6
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int c_num_legal_xlen = 4;
    localparam int c_legal_xlen [c_num_legal_xlen] = '{8, 16, 32, 64};

    // True when the op code is handled by the iterative mul/div unit.
    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_muldiv
// Description : Iterative datapath shared by MUL and, when built with the
//               macro ALU_MC_DIV_EN, by DIVU/REMU.
//               - MUL uses shift-add and returns the low XLEN bits.
//               - DIVU/REMU use restoring division.
//               The operands are loaded on start. One iteration runs per
//               clock. done is high in the cycle after the last of the
//               XLEN iterations.
// Ports       : clk, rst_n      - clock, async active-low reset
//               start, abort    - load operands / drop current operation
//               op              - op code, latched on start
//               a, b            - operands, sampled on start
//               done, result    - completion flag and result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [SHW:0] c_cnt_last = (SHW+1)'(XLEN);

    logic            r_busy;
    logic [SHW:0]    r_cnt;
    logic [XLEN-1:0] r_acc;   // product accumulator
    logic [XLEN-1:0] r_opa;   // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] r_opb;   // multiplier, or divisor
    logic [XLEN-1:0] w_acc_next;
    logic [XLEN-1:0] w_opa_next;
    logic [XLEN-1:0] w_opb_next;
`ifdef ALU_MC_DIV_EN
    logic            r_is_div;
    logic            r_is_rem;
    logic [XLEN-1:0] r_rem;
    logic [XLEN:0]   w_shifted;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem_next;
`endif

    always_comb begin
        w_acc_next = r_opb[0] ? (r_acc + r_opa) : r_acc;
        w_opa_next = r_opa << 1;
        w_opb_next = r_opb >> 1;
`ifdef ALU_MC_DIV_EN
        // Restoring step: keep the trial difference only if it did not go
        // negative. Divisor 0 never goes negative. This gives an all-ones
        // quotient and a remainder equal to the dividend.
        w_shifted  = {r_rem, r_opa[XLEN-1]};
        w_trial    = w_shifted - {1'b0, r_opb};
        w_rem_next = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
        if (r_is_div) begin
            w_opa_next = {r_opa[XLEN-2:0], ~w_trial[XLEN]};
            w_opb_next = r_opb;
        end
`endif
    end

    assign done = r_busy && (r_cnt == c_cnt_last);

`ifdef ALU_MC_DIV_EN
    assign result = r_is_div ? (r_is_rem ? r_rem : r_opa) : r_acc;
`else
    assign result = r_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
`ifdef ALU_MC_DIV_EN
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_rem    <= '0;
`endif
        end else if (abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= a;
            r_opb    <= b;
`ifdef ALU_MC_DIV_EN
            r_is_div <= (op == OP_DIVU) || (op == OP_REMU);
            r_is_rem <= (op == OP_REMU);
            r_rem    <= '0;
`endif
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_next;
                r_opa <= w_opa_next;
                r_opb <= w_opb_next;
`ifdef ALU_MC_DIV_EN
                r_rem <= w_rem_next;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with a valid/ready handshake at both ends.
//               - Single-cycle ops finish one cycle after accept.
//               - MUL (and DIVU/REMU when built with ALU_MC_DIV_EN) finish
//                 XLEN+1 cycles after accept.
//               - A branch compare of A and B is evaluated for every op.
// Ports       : clk, rst_n            - clock, async active-low reset
//               flush                 - drop any in-flight/undelivered op
//               in_valid, in_ready    - request handshake
//               op, cmp_op            - ALU op code, compare code
//               a, rs2, imm, b_sel    - operand A; B = b_sel ? rs2 : imm
//               out_valid, out_ready  - result handshake
//               result, branch        - outputs, held while out_valid=1
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [2:0]      cmp_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            b_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch
);

    alu_state_e      r_state;
    alu_state_e      w_next_state;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [3:0]      r_op;
    logic [2:0]      r_cmp;
    logic [XLEN-1:0] r_result;
    logic            r_branch;

    logic [XLEN-1:0] w_b_in;
    logic            w_accept;
    logic            w_finish;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;
    logic [SHW-1:0]  w_sh;
    logic [XLEN-1:0] w_alu_result;
    logic            w_branch_calc;

    assign w_b_in    = b_sel ? rs2 : imm;
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    // flush takes priority over a request presented in the same cycle.
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_finish  = (r_state == ST_BUSY) && (!is_iter_op(r_op) || w_md_done);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign branch    = r_branch;

    // The iterative unit loads straight from the request inputs at accept.
    // This keeps MUL/DIV latency at exactly XLEN+1.
    alu_mc_muldiv #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept && is_iter_op(op)),
        .abort  (flush),
        .op     (op),
        .a      (a),
        .b      (w_b_in),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
            ST_BUSY: if (w_finish) w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = w_accept ? ST_BUSY : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (flush) w_next_state = ST_IDLE;
    end

    always_comb begin
        w_sh         = r_b[SHW-1:0];
        w_alu_result = '0;
        case (r_op)
            OP_ADD:  w_alu_result = r_a + r_b;
            OP_SUB:  w_alu_result = r_a - r_b;
            OP_AND:  w_alu_result = r_a & r_b;
            OP_OR:   w_alu_result = r_a | r_b;
            OP_XOR:  w_alu_result = r_a ^ r_b;
            OP_SAME: w_alu_result = r_b;
            OP_SLL:  w_alu_result = r_a << w_sh;
            OP_SRL:  w_alu_result = r_a >> w_sh;
            OP_SRA:  w_alu_result = $signed(r_a) >>> w_sh;
            default: w_alu_result = '0;
        endcase
        if (is_iter_op(r_op)) w_alu_result = w_md_result;
    end

    // Signed compares use the native signed relational operators. They do
    // not depend on the sign of A-B, so they are overflow-correct.
    always_comb begin
        w_branch_calc = 1'b0;
        case (r_cmp)
            CMP_EQUAL:    w_branch_calc = (r_a == r_b);
            CMP_UNEQUAL:  w_branch_calc = (r_a != r_b);
            CMP_LESS:     w_branch_calc = ($signed(r_a) <  $signed(r_b));
            CMP_GREATER:  w_branch_calc = ($signed(r_a) >= $signed(r_b));
            CMP_LESSU:    w_branch_calc = (r_a <  r_b);
            CMP_GREATERU: w_branch_calc = (r_a >= r_b);
            default:      w_branch_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cmp    <= '0;
            r_result <= '0;
            r_branch <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= w_b_in;
                r_op  <= op;
                r_cmp <= cmp_op;
            end
            // Outputs change only on entry to DONE. They hold while the
            // consumer stalls.
            if (w_finish && !flush) begin
                r_result <= w_alu_result;
                r_branch <= w_branch_calc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc at XLEN=32.
//               - Directed cases cover reset, compares, shifts, MUL, DIVU,
//                 REMU, back-to-back issue, flush and reset mid-operation.
//               - These are followed by randomized ops checked against a
//                 behavioural model. The model honours ALU_MC_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int XLEN = 32;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            flush     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic            b_sel     = 1'b0;
    logic [3:0]      op        = '0;
    logic [2:0]      cmp_op    = '0;
    logic [XLEN-1:0] a         = '0;
    logic [XLEN-1:0] rs2       = '0;
    logic [XLEN-1:0] imm       = '0;
    logic            in_ready;
    logic            out_valid;
    logic            branch;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cmp_op    (cmp_op),
        .a         (a),
        .rs2       (rs2),
        .imm       (imm),
        .b_sel     (b_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .branch    (branch)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        int unsigned sh;
        sh = y % 32;
        prod = {32'd0, x} * {32'd0, y};
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SAME: return y;
            OP_SLL:  return x << sh;
            OP_SRL:  return x >> sh;
            OP_SRA:  return 32'($signed(x) >>> sh);
            OP_MUL:  return prod[31:0];
`ifdef ALU_MC_DIV_EN
            OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REMU: return (y == 0) ? x : x % y;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_branch(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        case (c)
            CMP_EQUAL:    return x == y;
            CMP_UNEQUAL:  return x != y;
            CMP_LESS:     return sx < sy;
            CMP_GREATER:  return sx >= sy;
            CMP_LESSU:    return x < y;
            CMP_GREATERU: return x >= y;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] o);
`ifdef ALU_MC_DIV_EN
        if (o == OP_DIVU || o == OP_REMU) return XLEN + 1;
`endif
        if (o == OP_MUL) return XLEN + 1;
        return 1;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    // Present a request at the falling edge. It is accepted at the next
    // rising edge. Afterwards the inputs are scrambled, because they are
    // don't-care once accepted.
    task automatic issue(input logic [3:0] o, input logic [2:0] c, input logic [31:0] av,
                         input logic [31:0] r2, input logic [31:0] iv, input logic bs);
        op = o; cmp_op = c; a = av; rs2 = r2; imm = iv; b_sel = bs; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom); cmp_op = 3'($urandom); a = $urandom; rs2 = $urandom; imm = $urandom;
        b_sel = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [2:0] c, input logic [31:0] av,
                          input logic [31:0] r2, input logic [31:0] iv, input logic bs, input int hold);
        logic [31:0] bv;
        logic [31:0] er;
        logic        eb;
        int          lat;
        int          cyc;
        logic        saw_ready;
        bv  = bs ? r2 : iv;
        er  = model_result(o, av, bv);
        eb  = model_branch(c, av, bv);
        lat = model_latency(o);
        check_eq("in_ready_idle", in_ready, 1);
        out_ready = 1'b0;
        issue(o, c, av, r2, iv, bs);
        cyc = 0;
        saw_ready = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) saw_ready = 1'b1;
            step();
            cyc++;
        end
        check_eq("latency", cyc, lat);
        check_eq("in_ready_busy", saw_ready, 0);
        check_eq("result", result, er);
        check_eq("branch", branch, eb);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_result", result, er);
            check_eq("hold_branch", branch, eb);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("valid_after_deliver", out_valid, 0);
    endtask

    logic seen;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_branch", branch, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);

        // Directed examples
        run_op(OP_SUB, CMP_EQUAL, 32'd5, 32'd5, 32'd0, 1'b1, 0);
        run_op(OP_ADD, CMP_LESS,  32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b1, 0);
        run_op(OP_ADD, CMP_LESSU, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b1, 0);
        run_op(OP_ADD, CMP_GREATER, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 0);
        run_op(OP_SRA, CMP_OTHER, 32'h8000_0000, 32'd0, 32'h21, 1'b0, 0);
        check_eq("sra_example", result, 32'hC000_0000);
        run_op(OP_MUL, CMP_UNEQUAL, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 1);
        run_op(OP_DIVU, CMP_EQUAL, 32'd7, 32'd0, 32'd0, 1'b1, 0);
        run_op(OP_REMU, CMP_GREATERU, 32'd7, 32'd0, 32'd0, 1'b1, 0);
        run_op(OP_DIVU, CMP_OTHER, 32'd100, 32'd7, 32'd0, 1'b1, 0);
        run_op(4'd14, CMP_GREATERU, 32'd9, 32'd3, 32'd0, 1'b1, 0);

        // Stall for three cycles, then issue back-to-back in the delivering cycle
        issue(OP_ADD, CMP_EQUAL, 32'd10, 32'd20, 32'd0, 1'b1);
        step();
        check_eq("b2b_first_valid", out_valid, 1);
        check_eq("b2b_first_result", result, 32'd30);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("b2b_stall_result", result, 32'd30);
            check_eq("b2b_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        op = OP_XOR; cmp_op = CMP_UNEQUAL; a = 32'hFF; rs2 = 32'h0F; b_sel = 1'b1; in_valid = 1'b1;
        #1;
        check_eq("b2b_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("b2b_busy_valid", out_valid, 0);
        step();
        check_eq("b2b_second_valid", out_valid, 1);
        check_eq("b2b_second_result", result, 32'hF0);
        check_eq("b2b_second_branch", branch, 1);
        step();
        out_ready = 1'b0;
        check_eq("b2b_idle", out_valid, 0);

        // Flush in the middle of a MUL
        issue(OP_MUL, CMP_OTHER, 32'd6, 32'd7, 32'd0, 1'b1);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_mul_idle", in_ready, 1);
        check_eq("flush_mul_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_eq("flush_mul_no_output", seen, 0);

        // A flush overrides a request presented in the same cycle
        op = OP_ADD; a = 32'd1; rs2 = 32'd1; b_sel = 1'b1; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_override_idle", in_ready, 1);
        step();
        check_eq("flush_override_valid", out_valid, 0);

        // A flush drops an undelivered result
        issue(OP_ADD, CMP_EQUAL, 32'd1, 32'd2, 32'd0, 1'b1);
        step();
        check_eq("flush_done_valid_before", out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_done_valid_after", out_valid, 0);

        // Reset during BUSY: outputs clear at once and nothing is delivered
        issue(OP_MUL, CMP_EQUAL, 32'd3, 32'd3, 32'd0, 1'b1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy_valid", out_valid, 0);
        check_eq("rst_busy_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst_busy_no_output", seen, 0);
        check_eq("rst_busy_in_ready", in_ready, 1);

        // Randomized ops against the model
        for (int n = 0; n < 80; n++) begin
            run_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), pick_val(), pick_val(),
                   pick_val(), 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
